// File: rtl/mod_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mod_dst_fifo
//  Description : Destination buffer between the DMA operation stage and the
//                write-back bus master. 32 x {last, 64-bit data} show-ahead
//                FIFO with full/almost-full backpressure, frame length
//                reporting and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_dst_fifo #(
   parameter int AW = 5,   // address width, depth is 2**AW
   parameter int AF = 4,   // almost-full when free slots <= AF
   parameter int AE = 1    // almost-empty when occupancy <= AE
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   // write side (operation stage)
   input  logic          m_dst_putn,
   input  logic [63:0]   m_dst,
   input  logic          m_dst_last,
   output logic          m_dst_full,
   output logic          m_dst_almost_full,
   // read side (write-back master)
   input  logic          wr_getn,
   output logic [63:0]   wr_dat,
   output logic          wr_last,
   output logic          wr_empty,
   output logic          wr_almost_empty,
   // frame and error reporting
   output logic          frame_done,
   output logic [15:0]   frame_len,
   output logic          ovf,
   output logic          udf
);

   localparam int          c_DEPTH    = 2 ** AW;
   localparam logic [AW:0] c_CNT_FULL = (AW+1)'(c_DEPTH);
   localparam logic [AW:0] c_CNT_AF   = (AW+1)'(c_DEPTH - AF);
   localparam logic [AW:0] c_CNT_AE   = (AW+1)'(AE);

   logic [64:0]   r_mem [c_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic [15:0]   r_words;
   logic [15:0]   r_frame_len;
   logic          r_frame_done;
   logic          r_ovf;
   logic          r_udf;

   logic          w_full;
   logic          w_empty;
   logic          w_put_ok;
   logic          w_get_ok;
   logic [64:0]   w_head;
   logic [15:0]   w_words_inc;

   // Acceptance looks only at registered occupancy, so a simultaneous get
   // never rescues a put into a full FIFO (and vice versa when empty).
   assign w_full      = (r_cnt == c_CNT_FULL);
   assign w_empty     = (r_cnt == '0);
   assign w_put_ok    = !m_dst_putn && !w_full;
   assign w_get_ok    = !wr_getn && !w_empty;
   assign w_head      = r_mem[r_rp];
   assign w_words_inc = (r_words == 16'hFFFF) ? r_words : r_words + 16'd1;

   assign m_dst_full        = w_full;
   assign m_dst_almost_full = (r_cnt >= c_CNT_AF);
   assign wr_empty          = w_empty;
   assign wr_almost_empty   = (r_cnt <= c_CNT_AE);
   assign wr_dat            = w_empty ? 64'd0 : w_head[63:0];
   assign wr_last           = !w_empty && w_head[64];
   assign frame_done        = r_frame_done;
   assign frame_len         = r_frame_len;
   assign ovf               = r_ovf;
   assign udf               = r_udf;

   // Storage array: written on accepted puts only, contents survive reset.
   always_ff @(posedge wb_clk_i) begin
      if (w_put_ok) begin
         r_mem[r_wp] <= {m_dst_last, m_dst};
      end
   end

   // Pointers, occupancy, frame tracking and sticky error flags.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         r_wp         <= '0;
         r_rp         <= '0;
         r_cnt        <= '0;
         r_words      <= '0;
         r_frame_len  <= '0;
         r_frame_done <= 1'b0;
         r_ovf        <= 1'b0;
         r_udf        <= 1'b0;
      end else begin
         if (w_put_ok) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_get_ok) begin
            r_rp <= r_rp + 1'b1;
         end

         case ({w_put_ok, w_get_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase

         if (!m_dst_putn && w_full) begin
            r_ovf <= 1'b1;
         end
         if (!wr_getn && w_empty) begin
            r_udf <= 1'b1;
         end

         // A frame ends when its last-tagged head word is popped.
         r_frame_done <= 1'b0;
         if (w_get_ok) begin
            if (w_head[64]) begin
               r_frame_len  <= w_words_inc;
               r_words      <= '0;
               r_frame_done <= 1'b1;
            end else begin
               r_words      <= w_words_inc;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mod_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_dst_fifo
//  Description : Directed self-checking bench for mod_dst_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_dst_fifo;

   logic          wb_clk_i;
   logic          wb_rst_i;
   logic          m_dst_putn;
   logic [63:0]   m_dst;
   logic          m_dst_last;
   logic          m_dst_full;
   logic          m_dst_almost_full;
   logic          wr_getn;
   logic [63:0]   wr_dat;
   logic          wr_last;
   logic          wr_empty;
   logic          wr_almost_empty;
   logic          frame_done;
   logic [15:0]   frame_len;
   logic          ovf;
   logic          udf;

   int checks;
   int errors;

   mod_dst_fifo #(.AW(5), .AF(4), .AE(1)) dut (
      .wb_clk_i          (wb_clk_i),
      .wb_rst_i          (wb_rst_i),
      .m_dst_putn        (m_dst_putn),
      .m_dst             (m_dst),
      .m_dst_last        (m_dst_last),
      .m_dst_full        (m_dst_full),
      .m_dst_almost_full (m_dst_almost_full),
      .wr_getn           (wr_getn),
      .wr_dat            (wr_dat),
      .wr_last           (wr_last),
      .wr_empty          (wr_empty),
      .wr_almost_empty   (wr_almost_empty),
      .frame_done        (frame_done),
      .frame_len         (frame_len),
      .ovf               (ovf),
      .udf               (udf)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
   endtask

   task automatic do_reset();
      wb_rst_i   = 1'b0;
      m_dst_putn = 1'b1;
      wr_getn    = 1'b1;
      m_dst_last = 1'b0;
      step();
      wb_rst_i   = 1'b1;
   endtask

   task automatic test_reset();
      wb_rst_i   = 1'b0;
      m_dst_putn = 1'b1;
      wr_getn    = 1'b1;
      m_dst      = 64'd0;
      m_dst_last = 1'b0;
      step();
      step();
      wb_rst_i = 1'b1;
      checks++; if (m_dst_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", m_dst_full); end
      checks++; if (m_dst_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", m_dst_almost_full); end
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", wr_empty); end
      checks++; if (wr_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", wr_almost_empty); end
      checks++; if (wr_dat !== 64'd0) begin errors++; $display("FAIL reset_dat got %h exp 0", wr_dat); end
      checks++; if (wr_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", wr_last); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone got %b exp 0", frame_done); end
      checks++; if (frame_len !== 16'd0) begin errors++; $display("FAIL reset_flen got %0d exp 0", frame_len); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      checks++; if (udf !== 1'b0) begin errors++; $display("FAIL reset_udf got %b exp 0", udf); end
   endtask

   task automatic test_basic_frame();
      logic [63:0] exp_w [3];
      exp_w[0] = 64'h1111_1111_1111_1111;
      exp_w[1] = 64'h2222_2222_2222_2222;
      exp_w[2] = 64'h3333_3333_3333_3333;
      for (int i = 0; i < 3; i++) begin
         m_dst_putn = 1'b0;
         m_dst      = exp_w[i];
         m_dst_last = (i == 2);
         step();
         if (i == 0) begin
            checks++; if (wr_empty !== 1'b0) begin errors++; $display("FAIL basic_latency_empty got %b exp 0", wr_empty); end
            checks++; if (wr_dat !== exp_w[0]) begin errors++; $display("FAIL basic_latency_dat got %h exp %h", wr_dat, exp_w[0]); end
         end
      end
      m_dst_putn = 1'b1;
      m_dst_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (wr_dat !== exp_w[i]) begin errors++; $display("FAIL basic_pop_dat[%0d] got %h exp %h", i, wr_dat, exp_w[i]); end
         checks++; if (wr_last !== (i == 2)) begin errors++; $display("FAIL basic_pop_last[%0d] got %b exp %b", i, wr_last, (i == 2)); end
         checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_early_fdone[%0d] got %b exp 0", i, frame_done); end
         wr_getn = 1'b0;
         step();
      end
      wr_getn = 1'b1;
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fdone got %b exp 1", frame_done); end
      checks++; if (frame_len !== 16'd3) begin errors++; $display("FAIL basic_flen got %0d exp 3", frame_len); end
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", wr_empty); end
      step();
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fdone_pulse got %b exp 0", frame_done); end
      checks++; if (frame_len !== 16'd3) begin errors++; $display("FAIL basic_flen_hold got %0d exp 3", frame_len); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 32; i++) begin
         m_dst_putn = 1'b0;
         m_dst      = 64'hF000_0000_0000_0000 | 64'(i);
         m_dst_last = 1'b0;
         step();
         if (i == 26) begin
            checks++; if (m_dst_almost_full !== 1'b0) begin errors++; $display("FAIL fill_afull27 got %b exp 0", m_dst_almost_full); end
         end
         if (i == 27) begin
            checks++; if (m_dst_almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull28 got %b exp 1", m_dst_almost_full); end
            checks++; if (m_dst_full !== 1'b0) begin errors++; $display("FAIL fill_full28 got %b exp 0", m_dst_full); end
         end
         if (i == 30) begin
            checks++; if (m_dst_full !== 1'b0) begin errors++; $display("FAIL fill_full31 got %b exp 0", m_dst_full); end
         end
         if (i == 31) begin
            checks++; if (m_dst_full !== 1'b1) begin errors++; $display("FAIL fill_full32 got %b exp 1", m_dst_full); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", ovf); end
         end
      end
      // 33rd put is dropped
      m_dst = 64'h0BAD_0BAD_0BAD_0BAD;
      step();
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
      checks++; if (m_dst_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full got %b exp 1", m_dst_full); end
      checks++; if (wr_dat !== 64'hF000_0000_0000_0000) begin errors++; $display("FAIL ovf_head got %h exp f000000000000000", wr_dat); end
      // put and get together while full: put dropped, one pop
      m_dst   = 64'h0000_0000_0000_DEAD;
      wr_getn = 1'b0;
      step();
      m_dst_putn = 1'b1;
      wr_getn    = 1'b1;
      checks++; if (m_dst_full !== 1'b0) begin errors++; $display("FAIL fullboth_full got %b exp 0", m_dst_full); end
      checks++; if (m_dst_almost_full !== 1'b1) begin errors++; $display("FAIL fullboth_afull got %b exp 1", m_dst_almost_full); end
      checks++; if (wr_dat !== 64'hF000_0000_0000_0001) begin errors++; $display("FAIL fullboth_head got %h exp f000000000000001", wr_dat); end
      // drain: exactly 31 words remain, the dropped puts never appear
      for (int i = 1; i < 32; i++) begin
         checks++; if (wr_dat !== (64'hF000_0000_0000_0000 | 64'(i))) begin errors++; $display("FAIL drain_dat[%0d] got %h exp %h", i, wr_dat, 64'hF000_0000_0000_0000 | 64'(i)); end
         wr_getn = 1'b0;
         step();
      end
      wr_getn = 1'b1;
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", wr_empty); end
      checks++; if (udf !== 1'b0) begin errors++; $display("FAIL drain_udf got %b exp 0", udf); end
   endtask

   task automatic test_empty_both();
      m_dst_putn = 1'b0;
      wr_getn    = 1'b0;
      m_dst      = 64'hCAFE_F00D_0000_0001;
      m_dst_last = 1'b0;
      step();
      m_dst_putn = 1'b1;
      wr_getn    = 1'b1;
      checks++; if (udf !== 1'b1) begin errors++; $display("FAIL emptyboth_udf got %b exp 1", udf); end
      checks++; if (wr_empty !== 1'b0) begin errors++; $display("FAIL emptyboth_empty got %b exp 0", wr_empty); end
      checks++; if (wr_dat !== 64'hCAFE_F00D_0000_0001) begin errors++; $display("FAIL emptyboth_dat got %h exp cafef00d00000001", wr_dat); end
      checks++; if (wr_almost_empty !== 1'b1) begin errors++; $display("FAIL emptyboth_aempty got %b exp 1", wr_almost_empty); end
      wr_getn = 1'b0;
      step();
      wr_getn = 1'b1;
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL emptyboth_drain got %b exp 1", wr_empty); end
   endtask

   task automatic test_stream_wrap();
      logic [64:0] q[$];
      logic [64:0] head;
      logic [15:0] exp_len [2];
      int          p;
      int          k;
      int          cyc;
      logic        exp_fd;
      exp_len[0] = 16'd40;
      exp_len[1] = 16'd60;
      p      = 0;
      k      = 0;
      cyc    = 0;
      exp_fd = 1'b0;
      while ((p < 100 || q.size() != 0 || exp_fd) && cyc < 3000) begin
         checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL stream_fdone cyc %0d got %b exp %b", cyc, frame_done, exp_fd); end
         if (exp_fd && k < 2) begin
            checks++; if (frame_len !== exp_len[k]) begin errors++; $display("FAIL stream_flen[%0d] got %0d exp %0d", k, frame_len, exp_len[k]); end
            k++;
         end
         exp_fd  = 1'b0;
         wr_getn = ($urandom_range(0, 2) == 0);
         if (!wr_getn && !wr_empty) begin
            head = q.pop_front();
            checks++; if ({wr_last, wr_dat} !== head) begin errors++; $display("FAIL stream_dat got %b_%h exp %b_%h", wr_last, wr_dat, head[64], head[63:0]); end
            exp_fd = head[64];
         end
         if (p < 100 && !m_dst_full) begin
            m_dst_putn = 1'b0;
            m_dst      = 64'hA5A5_0000_0000_0000 | 64'(p);
            m_dst_last = (p == 39) || (p == 99);
            q.push_back({m_dst_last, m_dst});
            p++;
         end else begin
            m_dst_putn = 1'b1;
            m_dst_last = 1'b0;
         end
         step();
         cyc++;
      end
      m_dst_putn = 1'b1;
      wr_getn    = 1'b1;
      m_dst_last = 1'b0;
      checks++; if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout cycles %0d limit 3000", cyc); end
      checks++; if (k !== 2) begin errors++; $display("FAIL stream_frames got %0d exp 2", k); end
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", wr_empty); end
   endtask

   task automatic test_reset_midframe();
      // set udf first so reset has a sticky flag to clear
      wr_getn = 1'b0;
      step();
      wr_getn = 1'b1;
      checks++; if (udf !== 1'b1) begin errors++; $display("FAIL mid_udf_pre got %b exp 1", udf); end
      for (int i = 0; i < 5; i++) begin
         m_dst_putn = 1'b0;
         m_dst      = 64'h7700_0000_0000_0000 | 64'(i);
         m_dst_last = 1'b0;
         step();
      end
      m_dst_putn = 1'b1;
      wr_getn    = 1'b0;
      step();
      step();
      wr_getn = 1'b1;
      checks++; if (wr_dat !== 64'h7700_0000_0000_0002) begin errors++; $display("FAIL mid_head got %h exp 7700000000000002", wr_dat); end
      do_reset();
      checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", wr_empty); end
      checks++; if (frame_len !== 16'd0) begin errors++; $display("FAIL mid_rst_flen got %0d exp 0", frame_len); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b exp 0", ovf); end
      checks++; if (udf !== 1'b0) begin errors++; $display("FAIL mid_rst_udf got %b exp 0", udf); end
      checks++; if (wr_dat !== 64'd0) begin errors++; $display("FAIL mid_rst_dat got %h exp 0", wr_dat); end
      // single-word frame after reset
      m_dst_putn = 1'b0;
      m_dst      = 64'h0123_4567_89AB_CDEF;
      m_dst_last = 1'b1;
      step();
      m_dst_putn = 1'b1;
      m_dst_last = 1'b0;
      checks++; if (wr_last !== 1'b1) begin errors++; $display("FAIL one_last got %b exp 1", wr_last); end
      wr_getn = 1'b0;
      step();
      wr_getn = 1'b1;
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL one_fdone got %b exp 1", frame_done); end
      checks++; if (frame_len !== 16'd1) begin errors++; $display("FAIL one_flen got %0d exp 1", frame_len); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic_frame();
      test_fill_overflow();
      test_empty_both();
      do_reset();
      test_stream_wrap();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_dst_fifo.md
# mod_dst_fifo

Destination buffer directly downstream of the DMA operation stage: it absorbs the 64-bit result words that stage emits on `m_dst_putn`/`m_dst`/`m_dst_last`, and returns the `m_dst_full`/`m_dst_almost_full` backpressure that stage consumes. On its read side it presents the words show-ahead to the write-back bus master. It tracks frame boundaries (words up to and including `last`), reports each frame's length, and flags overflow/underflow as sticky errors.

## Interface
- `AW`, 5: address width; depth `DEPTH = 2**AW` = 32 entries of 65 bits (64 data + last).
- `AF`, 4: almost-full threshold; asserted when free slots ≤ `AF`. This covers the producer's pipeline slack.
- `AE`, 1: almost-empty threshold; asserted when occupancy ≤ `AE`.
- `wb_clk_i`  in  1  sole clock; all logic on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-low.
- `m_dst_putn`  in  1  active-low write strobe from the operation stage.
- `m_dst`  in  64  write data.
- `m_dst_last`  in  1  marks the final word of a frame.
- `m_dst_full`  out  1  occupancy == `DEPTH`.
- `m_dst_almost_full`  out  1  occupancy ≥ `DEPTH-AF`.
- `wr_getn`  in  1  active-low pop strobe from the write-back master.
- `wr_dat`  out  64  head word; 0 when empty.
- `wr_last`  out  1  last tag of the head word; 0 when empty.
- `wr_empty`  out  1  occupancy == 0.
- `wr_almost_empty`  out  1  occupancy ≤ `AE`.
- `frame_done`  out  1  one-cycle pulse after the pop of a last-tagged word.
- `frame_len`  out  16  word count of the most recently completed frame.
- `ovf`  out  1  sticky; a put was attempted while full.
- `udf`  out  1  sticky; a get was attempted while empty.

## Operation
- Storage: flop array `mem[DEPTH]` of {last, data}. Write pointer `wp` and read pointer `rp` are `AW` bits wide and wrap modulo `DEPTH`. Occupancy `cnt` is `AW+1` bits wide, range 0..`DEPTH`.
- Put accepted: `m_dst_putn==0 && cnt!=DEPTH`.
  - Writes {`m_dst_last`,`m_dst`} at `wp`.
  - `wp`+1.
- Get accepted: `wr_getn==0 && cnt!=0`.
  - `rp`+1.
- Acceptance uses the registered `cnt` only. A put while full is dropped even if a get happens in the same cycle. A get while empty is ignored even if a put happens in the same cycle.
- `cnt` update: +1 on put only; −1 on get only; unchanged when both or neither are accepted.
- Rejected put sets `ovf`. Rejected get sets `udf`. Both stay set until reset. Rejected operations change no pointer or data.
- Show-ahead read: `wr_dat`/`wr_last` = `mem[rp]` combinationally, gated to 0 while `cnt==0`.
- Flags decode combinationally from registered `cnt`, so they reflect state after the previous edge.
- Frame tracking:
  - `words` is a 16-bit counter that increments on each accepted get and saturates at 16'hFFFF.
  - On an accepted get with `wr_last==1`:
    - `frame_len` ← saturating(`words`+1).
    - `words` ← 0.
    - `frame_done` ← 1 for the next cycle.
  - `frame_len` holds its value until the next frame completes.
- Reset (`wb_rst_i==0` at an edge) clears pointers, `cnt`, `words`, `frame_len`, `frame_done`, `ovf` and `udf`. Array contents are not reset. Any words in flight are discarded.

## Timing
- Reset values: `m_dst_full`=0, `m_dst_almost_full`=0, `wr_empty`=1, `wr_almost_empty`=1, `wr_dat`=0, `wr_last`=0, `frame_done`=0, `frame_len`=0, `ovf`=0, `udf`=0.
- Write-to-read latency: a word put at edge N is visible on `wr_dat` with `wr_empty`=0 after edge N, i.e. in cycle N+1.
- Pop: with `wr_getn` low at edge N, the next word appears after edge N. Back-to-back pops every cycle are allowed.
- Full/empty flags update one cycle after the causing edge. There is no combinational path from `m_dst_putn` or `wr_getn` to any output.
- `frame_done` is high during the cycle after the edge that popped the last-tagged word. `frame_len` is valid in that same cycle.
- A reset asserted mid-frame yields the reset values after that edge. A `last` word popped on the reset edge produces no `frame_done`.
- Throughput: one put and one get per cycle, sustained.

## Test plan
- Reset, then put 0x1111…, 0x2222… and 0x3333… (last on the third), then pop all three -> `wr_dat` follows the put order; `frame_done` pulses once; `frame_len`=3; `wr_empty`=1 afterwards.
- Put 28 words without popping -> `m_dst_almost_full`=1 after the 28th put edge. Put 4 more -> `m_dst_full`=1. Attempt a 33rd put -> `ovf`=1 and `cnt` stays 32.
- Full FIFO, with put and get asserted together for 1 cycle -> the put is dropped (`ovf`=1), one word is popped, and `cnt`=31.
- Empty FIFO, with put and get asserted together -> `udf`=1, the word is stored, `wr_empty`=0 next cycle, and `wr_dat` = the put data.
- Stream 100 words with last on word 40 and word 100, using random `wr_getn` gaps with the pointers wrapping -> data matches the scoreboard; `frame_len`=40, then 60.
- Put 5 words, pop 2 (no last), then assert reset -> after the edge, `wr_empty`=1, `frame_len`=0 and `ovf`/`udf`=0. A new 1-word frame yields `frame_len`=1.
